cim_mul_sequencer: RTL

Controller that sequences one signed 4x4 multiply on the in-memory multiplier macro per request. It accepts operands on a valid/ready handshake and writes them and a cleared sum row into the macro. It then runs two precharge/evaluate phases: the first shifted by two, the second passed through. Finally it captures the macro sum, presents the product on a valid/ready output and checks it against a reference product.

---
 rtl/cim_mul_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cim_mul_sequencer.sv
// Sequences one signed 4x4 multiply on the in-memory multiplier macro per request,
// then captures the macro sum row and optionally checks it against A*B.
module cim_mul_sequencer #(
    parameter int unsigned PRE_CYC  = 1,
    parameter int unsigned EVAL_CYC = 1,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_A,
    input  logic [3:0] IN_B,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_P,
    input  logic [7:0] SUM,
    output logic [1:0] WWL1,
    output logic [1:0] RWL1,
    output logic [7:0] WBL1,
    output logic [7:0] WBL1b,
    output logic       F,
    output logic [1:0] WWL,
    output logic [1:0] RWL,
    output logic [7:0] WBL,
    output logic [7:0] WBLb,
    output logic       RWWL,
    output logic [7:0] RWBL,
    output logic [7:0] RWBLb,
    output logic       MUL,
    output logic       Shift,
    output logic       NShift,
    output logic       MISMATCH,
    output logic [7:0] ERR_CNT
);

    localparam int unsigned MAXC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] EVAL_LD = CW'(EVAL_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PRE1, EV1, PRE2, EV2, CAPT, HOLD} state_t;

    typedef struct packed {
        logic [1:0] wwl1;
        logic [1:0] rwl1;
        logic       f;
        logic [1:0] wwl;
        logic [1:0] rwl;
        logic       rwwl;
        logic       mul;
        logic       shift;
        logic       nshift;
    } ctl_t;

    state_t        state;
    ctl_t          ctl;
    logic [CW-1:0] cnt;
    logic [3:0]    a_r, b_r;
    logic [7:0]    wbl_r, rwbl_r;
    logic [7:0]    exp_p;

    function automatic logic [7:0] sext(input logic [3:0] v);
        return {{4{v[3]}}, v};
    endfunction

    // Control pattern held for the whole of each state; loaded on the entry edge.
    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            LOAD: begin c.wwl1 = 2'b11; c.wwl = 2'b10; c.rwwl = 1'b1; end
            PRE1, PRE2: begin c.f = 1'b1; c.mul = 1'b1; end
            EV1: begin
                c.wwl1 = 2'b01; c.rwl1 = 2'b10; c.wwl = 2'b01; c.rwl = 2'b10;
                c.mul = 1'b1; c.shift = 1'b1; c.rwwl = 1'b1;
            end
            EV2: begin
                c.wwl1 = 2'b10; c.rwl1 = 2'b01; c.wwl = 2'b10; c.rwl = 2'b01;
                c.mul = 1'b1; c.nshift = 1'b1; c.rwwl = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign exp_p = sext(a_r) * sext(b_r);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            ctl       <= '0;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            wbl_r     <= '0;
            rwbl_r    <= '0;
            IN_READY  <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_P     <= '0;
            MISMATCH  <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            MISMATCH <= 1'b0;
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        a_r      <= IN_A;
                        b_r      <= IN_B;
                        wbl_r    <= sext(IN_A);
                        rwbl_r   <= sext(IN_B);
                        IN_READY <= 1'b0;
                        state    <= LOAD;
                        ctl      <= ctl_for(LOAD);
                        cnt      <= '0;
                    end else begin
                        IN_READY <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= PRE1;
                    ctl   <= ctl_for(PRE1);
                    cnt   <= PRE_LD;
                end
                PRE1: begin
                    if (cnt == '0) begin
                        state <= EV1;
                        ctl   <= ctl_for(EV1);
                        cnt   <= EVAL_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EV1: begin
                    if (cnt == '0) begin
                        state <= PRE2;
                        ctl   <= ctl_for(PRE2);
                        cnt   <= PRE_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRE2: begin
                    if (cnt == '0) begin
                        state <= EV2;
                        ctl   <= ctl_for(EV2);
                        cnt   <= EVAL_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EV2: begin
                    if (cnt == '0) begin
                        state <= CAPT;
                        ctl   <= ctl_for(CAPT);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPT: begin
                    OUT_P     <= SUM;
                    OUT_VALID <= 1'b1;
                    state     <= HOLD;
                    ctl       <= ctl_for(HOLD);
                    cnt       <= '0;
                    // Mismatch pulse lines up with OUT_VALID rising.
                    if (CHECK_EN && (SUM != exp_p)) begin
                        MISMATCH <= 1'b1;
                        if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                        ctl       <= ctl_for(IDLE);
                        cnt       <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    assign WWL1   = ctl.wwl1;
    assign RWL1   = ctl.rwl1;
    assign F      = ctl.f;
    assign WWL    = ctl.wwl;
    assign RWL    = ctl.rwl;
    assign RWWL   = ctl.rwwl;
    assign MUL    = ctl.mul;
    assign Shift  = ctl.shift;
    assign NShift = ctl.nshift;
    assign WBL1   = '0;
    assign WBL1b  = ~WBL1;
    assign WBL    = wbl_r;
    assign WBLb   = ~wbl_r;
    assign RWBL   = rwbl_r;
    assign RWBLb  = ~rwbl_r;

endmodule
